write_back: RTL and testbench
=============================

// Module: write_back
// PURPOSE
//  Final pipeline stage, directly downstream of the memory stage. Registers the memory-stage
//  results, selects the write-back value (ALU/MEM/FPU/link) and drives the register-file write port.
//  Also exports a bypass copy of the last committed write, counts retired instructions and halts on TRAP.
// PARAMETERS
//  CNT_W        32      width of RetireCount
//  TRAP_OPCODE  6'h11   opcode that halts the core when it commits
//  NOP_FUNCT    6'h15   funct of the bubble encoding (opcode 6'h00): not counted as retired
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-low reset
//  stall          in   1   1 = hold stage register, no commit this cycle
//  NextDInSrc     in   2   00 ALU, 01 MEM, 10 FPU, 11 PC+4 (link)
//  NextRegWE      in   1   instruction writes a register
//  NextRegWAddr   in   6   0-31 integer regs, 32-63 FP regs
//  NextMEMDout    in   32  load data from memory stage
//  NextALUOut     in   32  ALU result
//  NextFPUOut     in   32  FPU result
//  NextPCPlusFour in   32  link value
//  NextOpcode     in   6   opcode
//  NextFunct      in   6   funct
//  RegWE          out  1   register-file write enable (commit)
//  RegWAddr       out  6   register-file write address
//  RegWData       out  32  register-file write data
//  PrevWE         out  1   previous committed write valid (bypass)
//  PrevWAddr      out  6   previous committed write address
//  PrevWData      out  32  previous committed write data
//  RetireCount    out  CNT_W  retired-instruction count
//  Halted         out  1   sticky: TRAP has committed
// BEHAVIOUR
//  - Stage register (src, we, waddr, opcode, funct, 4 data words) loads Next* when reset=1 & stall=0;
//    holds when stall=1. Latency: Next* on edge N -> commit outputs valid during cycle N+1.
//  - RegWData = mux(src): 00 ALU, 01 MEM, 10 FPU, 11 PC+4. Combinational from stage register.
//  - commit = !stall & !Halted. RegWE = commit & we & (waddr != 0). RegWAddr/RegWData always
//    driven from stage register; consumers use RegWE only.
//  - Held instruction under stall commits exactly once: on first cycle with stall=0.
//  - Prev*: on every cycle with RegWE=1, Prev* <= {1, RegWAddr, RegWData}; otherwise hold.
//  - Retire: bubble = (opcode==0 & funct==NOP_FUNCT). On commit & !bubble, RetireCount += 1,
//    wraps modulo 2^CNT_W (all-ones -> 0). Write enable of the instruction irrelevant.
//  - FSM: RUN -> HALTED when commit & opcode==TRAP_OPCODE (TRAP itself counts as retired,
//    its RegWE per normal rule). HALTED: Halted=1, RegWE=0, count frozen, Prev* frozen,
//    stage register keeps loading. Exit HALTED only via reset.
//  - Reset (reset=0 at edge, any cycle incl. mid-stall or HALTED): stage register <= bubble
//    (opcode 0, funct NOP_FUNCT, we 0, src 00, waddr 0, data 0); RegWE=0, RegWAddr=0, RegWData=0,
//    PrevWE=0, PrevWAddr=0, PrevWData=0, RetireCount=0, Halted=0, state RUN. Reset wins over stall.
//  - Simultaneous stall & TRAP resident: no commit, no halt until stall drops.
// TESTING
//  1 ALU: NextDInSrc=00, NextRegWE=1, NextRegWAddr=5, NextALUOut=32'h1234 -> next cycle RegWE=1,
//    RegWAddr=5, RegWData=32'h1234, RetireCount=1; following cycle PrevWE=1, PrevWData=32'h1234.
//  2 Source mux: MEM=32'hAAAA0001, FPU=32'h3F800000, PC+4=32'h104 with src 01/10/11, addr 33
//    -> RegWData matches each in turn, RegWAddr=33.
//  3 R0: NextRegWAddr=0, NextRegWE=1 -> RegWE=0, Prev* unchanged, RetireCount still +1.
//  4 Stall: load addr 7, hold stall=1 for 3 cycles -> RegWE=0 throughout; on release one
//    RegWE pulse, RetireCount +1 only; bubbles (opcode 0/funct 6'h15) never counted.
//  5 TRAP: commit opcode 6'h11 -> Halted=1 next cycle, later writes RegWE=0, count frozen;
//    RetireCount preset to all-ones then one retire -> wraps to 0.
//  6 Reset mid-stall while HALTED: reset=0 one edge -> all outputs 0, Halted=0, RUN resumes.

Source files
------------

// File: rtl/write_back.sv
// Final pipeline stage: registers memory-stage results, drives the
// register-file write port, bypass copy, retire counter and TRAP halt.
module write_back #(
  parameter int         CNT_W       = 32,
  parameter logic [5:0] TRAP_OPCODE = 6'h11,
  parameter logic [5:0] NOP_FUNCT   = 6'h15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       NextDInSrc,
  input  logic             NextRegWE,
  input  logic [5:0]       NextRegWAddr,
  input  logic [31:0]      NextMEMDout,
  input  logic [31:0]      NextALUOut,
  input  logic [31:0]      NextFPUOut,
  input  logic [31:0]      NextPCPlusFour,
  input  logic [5:0]       NextOpcode,
  input  logic [5:0]       NextFunct,
  output logic             RegWE,
  output logic [5:0]       RegWAddr,
  output logic [31:0]      RegWData,
  output logic             PrevWE,
  output logic [5:0]       PrevWAddr,
  output logic [31:0]      PrevWData,
  output logic [CNT_W-1:0] RetireCount,
  output logic             Halted
);

  typedef struct packed {
    logic [1:0]  src;
    logic        we;
    logic [5:0]  waddr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] fpu;
    logic [31:0] pc4;
  } wb_t;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  wb_t    st;
  state_t state;
  logic   commit;
  logic   bubble;

  assign commit   = !stall && (state == RUN);
  assign bubble   = (st.opcode == 6'h00) &&
                    (st.funct == NOP_FUNCT);
  assign RegWE    = commit && st.we &&
                    (st.waddr != 6'd0);
  assign RegWAddr = st.waddr;

  // Stage register: load when not stalled, reset to a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= '0;
      st.funct  <= NOP_FUNCT;
    end else if (!stall) begin
      st.src    <= NextDInSrc;
      st.we     <= NextRegWE;
      st.waddr  <= NextRegWAddr;
      st.opcode <= NextOpcode;
      st.funct  <= NextFunct;
      st.mem    <= NextMEMDout;
      st.alu    <= NextALUOut;
      st.fpu    <= NextFPUOut;
      st.pc4    <= NextPCPlusFour;
    end
  end

  // Write-back data source select.
  always_comb begin
    RegWData = st.alu;
    unique case (1'b1)
      (st.src == 2'b00): RegWData = st.alu;
      (st.src == 2'b01): RegWData = st.mem;
      (st.src == 2'b10): RegWData = st.fpu;
      (st.src == 2'b11): RegWData = st.pc4;
      default:           RegWData = st.alu;
    endcase
  end

  // Bypass copy of the last committed register write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      PrevWE    <= 1'b0;
      PrevWAddr <= 6'd0;
      PrevWData <= 32'd0;
    end else if (RegWE) begin
      PrevWE    <= 1'b1;
      PrevWAddr <= RegWAddr;
      PrevWData <= RegWData;
    end
  end

  // Retired-instruction counter, bubbles excluded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RetireCount <= '0;
    end else if (commit && !bubble) begin
      RetireCount <= RetireCount + CNT_W'(1);
    end
  end

  // Run/halt FSM: a committed TRAP halts until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= RUN;
      Halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (commit && st.opcode == TRAP_OPCODE) begin
            state  <= HALT;
            Halted <= 1'b1;
          end
        end
        HALT: begin
          state  <= HALT;
          Halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          Halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Testbench for write_back: directed steps then random traffic,
// compared against an instruction-level reference model.
module tb_write_back;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [1:0]    NextDInSrc;
  logic          NextRegWE;
  logic [5:0]    NextRegWAddr;
  logic [31:0]   NextMEMDout;
  logic [31:0]   NextALUOut;
  logic [31:0]   NextFPUOut;
  logic [31:0]   NextPCPlusFour;
  logic [5:0]    NextOpcode;
  logic [5:0]    NextFunct;
  logic          RegWE;
  logic [5:0]    RegWAddr;
  logic [31:0]   RegWData;
  logic          PrevWE;
  logic [5:0]    PrevWAddr;
  logic [31:0]   PrevWData;
  logic [CW-1:0] RetireCount;
  logic          Halted;

  int checks = 0;
  int errors = 0;

  write_back #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .NextDInSrc(NextDInSrc), .NextRegWE(NextRegWE),
    .NextRegWAddr(NextRegWAddr), .NextMEMDout(NextMEMDout),
    .NextALUOut(NextALUOut), .NextFPUOut(NextFPUOut),
    .NextPCPlusFour(NextPCPlusFour), .NextOpcode(NextOpcode),
    .NextFunct(NextFunct), .RegWE(RegWE), .RegWAddr(RegWAddr),
    .RegWData(RegWData), .PrevWE(PrevWE), .PrevWAddr(PrevWAddr),
    .PrevWData(PrevWData), .RetireCount(RetireCount),
    .Halted(Halted)
  );

  always #5 clk = ~clk;

  // reference model: the instruction currently resident in the stage
  typedef struct {
    int          src;
    bit          we;
    int          waddr;
    int          opcode;
    int          funct;
    logic [31:0] d[4];
  } instr_t;

  instr_t      res;
  bit          m_halted;
  int          m_cnt;
  bit          m_pwe;
  int          m_paddr;
  logic [31:0] m_pdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit stl, input int src,
                      input bit we, input int wa, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] fpu,
                      input logic [31:0] pc4, input int op,
                      input int fn, input bit do_chk);
    bit          commit;
    bit          e_we;
    logic [31:0] e_data;
    @(negedge clk);
    reset          = rst;
    stall          = stl;
    NextDInSrc     = 2'(src);
    NextRegWE      = we;
    NextRegWAddr   = 6'(wa);
    NextALUOut     = alu;
    NextMEMDout    = mem;
    NextFPUOut     = fpu;
    NextPCPlusFour = pc4;
    NextOpcode     = 6'(op);
    NextFunct      = 6'(fn);
    #1;
    commit = !stl && !m_halted;
    e_we   = commit && res.we && res.waddr != 0;
    e_data = res.d[res.src];
    if (do_chk) begin
      chk("RegWE", {31'b0, RegWE}, {31'b0, e_we});
      chk("RegWAddr", {26'b0, RegWAddr}, 32'(res.waddr));
      chk("RegWData", RegWData, e_data);
      chk("PrevWE", {31'b0, PrevWE}, {31'b0, m_pwe});
      chk("PrevWAddr", {26'b0, PrevWAddr}, 32'(m_paddr));
      chk("PrevWData", PrevWData, m_pdata);
      chk("RetireCount", {28'b0, RetireCount}, 32'(m_cnt));
      chk("Halted", {31'b0, Halted}, {31'b0, m_halted});
    end
    // state after the coming rising edge
    if (!rst) begin
      res.src = 0; res.we = 0; res.waddr = 0;
      res.opcode = 0; res.funct = 'h15;
      res.d = '{32'h0, 32'h0, 32'h0, 32'h0};
      m_halted = 0; m_cnt = 0;
      m_pwe = 0; m_paddr = 0; m_pdata = '0;
    end else begin
      if (e_we) begin
        m_pwe = 1; m_paddr = res.waddr; m_pdata = e_data;
      end
      if (commit && !(res.opcode == 0 && res.funct == 'h15))
        m_cnt = (m_cnt + 1) % (1 << CW);
      if (commit && res.opcode == 'h11) m_halted = 1;
      if (!stl) begin
        res.src = src; res.we = we; res.waddr = wa;
        res.opcode = op; res.funct = fn;
        res.d = '{alu, mem, fpu, pc4};
      end
    end
  endtask

  task automatic nop(input bit rst, input bit stl);
    step(rst, stl, 0, 0, 0, 0, 0, 0, 0, 0, 'h15, 1);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h15, 0);
    nop(1, 0);
    // ALU write to r5
    step(1, 0, 0, 1, 5, 32'h1234, 0, 0, 0, 1, 0, 1);
    nop(1, 0);
    nop(1, 0);
    // source mux, addr 33
    for (int s = 1; s < 4; s++)
      step(1, 0, s, 1, 33, 32'h55, 32'hAAAA0001,
           32'h3F800000, 32'h104, 2, 0, 1);
    nop(1, 0);
    // write to r0
    step(1, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 3, 0, 1);
    nop(1, 0);
    // stall with a resident instruction
    step(1, 0, 0, 1, 7, 32'h77, 0, 0, 0, 4, 1, 1);
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 9, 32'h99, 0, 0, 0, 4, 1, 1);
    nop(1, 0);
    nop(1, 0);
    // stall with TRAP resident, then release
    step(1, 0, 0, 1, 3, 32'h33, 0, 0, 0, 'h11, 0, 1);
    nop(1, 1);
    nop(1, 1);
    step(1, 0, 0, 1, 4, 32'h44, 0, 0, 0, 5, 0, 1);
    step(1, 0, 0, 1, 6, 32'h66, 0, 0, 0, 5, 0, 1);
    nop(1, 1);
    // reset mid-stall while halted
    nop(0, 1);
    nop(1, 0);
    // counter wrap: 17 retires on a 4-bit counter
    for (int i = 0; i < 17; i++)
      step(1, 0, i % 4, 1, i + 1, 32'(i), 32'(i * 3),
           32'(i * 5), 32'(i * 7), 8, 0, 1);
    nop(1, 0);
    nop(1, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      int op, fn, r;
      r  = $urandom_range(0, 19);
      op = (r < 4) ? 0 : (r == 4) ? 'h11 : $urandom_range(1, 63);
      fn = (r < 3) ? 'h15 : $urandom_range(0, 63);
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 3), $urandom_range(0, 1),
           ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 63),
           $urandom, $urandom, $urandom, $urandom, op, fn, 1);
    end
    nop(1, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
